// File: rtl/seg7_display_ctrl_if.sv
// rtl/seg7_display_ctrl_if.sv - load/status/segment bundle between GPIO export and seg7_display_ctrl
interface seg7_display_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    logic                    load_i;
    logic                    mode_i;
    logic [4*NUM_DIGITS-1:0] value_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   blink_i;
    logic                    busy_o;
    logic                    ovf_o;
    logic [8*NUM_DIGITS-1:0] seg_o;

    modport master (
        output load_i, mode_i, value_i, dp_i, blink_i,
        input  busy_o, ovf_o, seg_o
    );

    modport slave (
        input  load_i, mode_i, value_i, dp_i, blink_i,
        output busy_o, ovf_o, seg_o
    );
endinterface

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - registered hex/decimal seven-segment driver with DP, blink and overflow
// Optional: SEG7_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module seg7_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_W      = 20,
    parameter int BLINK_DIV  = 4000000
) (
    input  logic               clk,
    input  logic               reset,
    seg7_display_ctrl_if.slave bus
);
    localparam int DW    = 4 * NUM_DIGITS;
    localparam int BCD_W = DW + 4;
    localparam int CW    = $clog2(BIN_W + 1);
    localparam int BCW   = $clog2(BLINK_DIV + 1);
    localparam logic [CW-1:0]  CONV_LAST  = CW'(BIN_W - 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [8*NUM_DIGITS-1:0] SEG_RESET = {{(NUM_DIGITS-1){8'hFF}}, 8'hC0};
`else
    localparam logic [8*NUM_DIGITS-1:0] SEG_RESET = {NUM_DIGITS{8'hC0}};
`endif

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                  state_q;
    logic                    busy_q, ovf_q, mode_q, conv_ovf_q;
    logic [DW-1:0]           value_q, dig_q;
    logic [NUM_DIGITS-1:0]   dp_ld_q, blink_ld_q, dp_q, blink_q;
    logic [BIN_W-1:0]        bin_q;
    logic [BCD_W-1:0]        bcd_q, bcd_adj;
    logic [CW-1:0]           conv_cnt_q;
    logic [BCW-1:0]          blink_cnt_q;
    logic                    phase_q;
    logic [8*NUM_DIGITS-1:0] seg_q, seg_d;

    function automatic logic [7:0] hex_enc(input logic [3:0] n);
        case (n)
            4'h0: hex_enc = 8'hC0;  4'h1: hex_enc = 8'hF9;
            4'h2: hex_enc = 8'hA4;  4'h3: hex_enc = 8'hB0;
            4'h4: hex_enc = 8'h99;  4'h5: hex_enc = 8'h92;
            4'h6: hex_enc = 8'h82;  4'h7: hex_enc = 8'hF8;
            4'h8: hex_enc = 8'h80;  4'h9: hex_enc = 8'h90;
            4'hA: hex_enc = 8'h88;  4'hB: hex_enc = 8'h83;
            4'hC: hex_enc = 8'hC6;  4'hD: hex_enc = 8'hA1;
            4'hE: hex_enc = 8'h86;  default: hex_enc = 8'h8E;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k <= NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // A bit shifted out of the top BCD nibble also means the value did not fit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            mode_q     <= 1'b0;
            conv_ovf_q <= 1'b0;
            value_q    <= '0;
            dig_q      <= '0;
            dp_ld_q    <= '0;
            blink_ld_q <= '0;
            dp_q       <= '0;
            blink_q    <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            conv_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load_i) begin
                        mode_q     <= bus.mode_i;
                        value_q    <= bus.value_i;
                        dp_ld_q    <= bus.dp_i;
                        blink_ld_q <= bus.blink_i;
                        bin_q      <= bus.value_i[BIN_W-1:0];
                        bcd_q      <= '0;
                        conv_cnt_q <= '0;
                        conv_ovf_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= bus.mode_i ? CONVERT : COMMIT;
                    end
                end
                CONVERT: begin
                    bcd_q      <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                    bin_q      <= bin_q << 1;
                    conv_ovf_q <= conv_ovf_q | bcd_adj[BCD_W-1];
                    conv_cnt_q <= conv_cnt_q + CW'(1);
                    if (conv_cnt_q == CONV_LAST) state_q <= COMMIT;
                end
                COMMIT: begin
                    dig_q   <= mode_q ? bcd_q[DW-1:0] : value_q;
                    dp_q    <= dp_ld_q;
                    blink_q <= blink_ld_q;
                    ovf_q   <= mode_q & (conv_ovf_q | (bcd_q[BCD_W-1 -: 4] != 4'd0));
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BCW'(1);
        end
    end

    logic [7:0] byte_v;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic       lead;
`endif
    always_comb begin
        seg_d  = '1;
        byte_v = '1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lead   = 1'b1;
`endif
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            byte_v = ovf_q ? 8'hBF : hex_enc(dig_q[4*i +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (dig_q[4*i +: 4] != 4'd0) lead = 1'b0;
            if (lead && !ovf_q && i != 0) byte_v = 8'hFF;
`endif
            if (dp_q[i]) byte_v[7] = 1'b0;
            if (blink_q[i] && phase_q) byte_v = 8'hFF;
            seg_d[8*i +: 8] = byte_v;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) seg_q <= SEG_RESET;
        else       seg_q <= seg_d;
    end

    assign bus.busy_o = busy_q;
    assign bus.ovf_o  = ovf_q;
    assign bus.seg_o  = seg_q;
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - scoreboard bench for seg7_display_ctrl (honours SEG7_LEADING_ZERO_BLANK_EN)
module tb_seg7_display_ctrl;
    logic clk;
    logic reset;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    seg7_display_ctrl_if #(.NUM_DIGITS(6)) bus ();

    seg7_display_ctrl #(.NUM_DIGITS(6), .BIN_W(20), .BLINK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        bit          mode;
        logic [23:0] value;
        logic [5:0]  dp;
        logic [5:0]  blink;
        int          busy;
    } txn_t;

    txn_t sb[$];

    function automatic logic [7:0] enc(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
           12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; 15: return 8'h8E;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit model_ovf(input bit mode, input logic [23:0] v);
        return mode && (v[19:0] >= 20'd1000000);
    endfunction

    function automatic logic [47:0] model_seg(input bit mode, input logic [23:0] v,
                                              input logic [5:0] dp, input logic [5:0] bl,
                                              input bit phase);
        int          d[6];
        int          x;
        bit          ovf;
        logic [7:0]  b;
        logic [47:0] r;
        ovf = model_ovf(mode, v);
        x   = int'(v[19:0]);
        for (int i = 0; i < 6; i++) begin
            if (mode) begin
                d[i] = x % 10;
                x    = x / 10;
            end else begin
                d[i] = int'(v[4*i +: 4]);
            end
        end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin
            int msd;
            msd = 0;
            for (int i = 0; i < 6; i++) if (d[i] != 0) msd = i;
            for (int i = 0; i < 6; i++) begin
                b = ovf ? 8'hBF : enc(d[i]);
                if (!ovf && i > msd) b = 8'hFF;
                if (dp[i]) b[7] = 1'b0;
                if (bl[i] && phase) b = 8'hFF;
                r[8*i +: 8] = b;
            end
        end
`else
        for (int i = 0; i < 6; i++) begin
            b = ovf ? 8'hBF : enc(d[i]);
            if (dp[i]) b[7] = 1'b0;
            if (bl[i] && phase) b = 8'hFF;
            r[8*i +: 8] = b;
        end
`endif
        return r;
    endfunction

    function automatic bit cur_phase();
        return (((cyc - 1) / 4) % 2) != 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input string tag, input bit mode, input logic [23:0] value,
                           input logic [5:0] dp, input logic [5:0] blink, input int glitch_at);
        txn_t        t;
        int          n;
        bit          stable;
        logic [47:0] first;
        @(negedge clk);
        bus.load_i  = 1'b1;
        bus.mode_i  = mode;
        bus.value_i = value;
        bus.dp_i    = dp;
        bus.blink_i = blink;
        t = '{mode, value, dp, blink, mode ? 21 : 1};
        sb.push_back(t);
        @(negedge clk);
        bus.load_i = 1'b0;
        n      = 0;
        stable = 1'b1;
        first  = bus.seg_o;
        while (bus.busy_o === 1'b1 && n < 100) begin
            n++;
            if (bus.seg_o !== first) stable = 1'b0;
            if (n == glitch_at) begin
                bus.load_i  = 1'b1;
                bus.mode_i  = 1'b0;
                bus.value_i = 24'h000777;
            end else begin
                bus.load_i = 1'b0;
            end
            @(negedge clk);
        end
        bus.load_i = 1'b0;
        t = sb.pop_front();
        check({tag, ".busy"}, 64'(n), 64'(t.busy));
        check({tag, ".ovf"}, 64'(bus.ovf_o), 64'(model_ovf(t.mode, t.value)));
        if (t.mode) check({tag, ".stable"}, 64'(stable), 64'd1);
        @(negedge clk);
        check({tag, ".seg"}, 64'(bus.seg_o),
              64'(model_seg(t.mode, t.value, t.dp, t.blink, cur_phase())));
    endtask

    initial begin
        reset       = 1'b1;
        bus.load_i  = 1'b0;
        bus.mode_i  = 1'b0;
        bus.value_i = '0;
        bus.dp_i    = '0;
        bus.blink_i = '0;
        repeat (3) @(negedge clk);
        check("rst.seg", 64'(bus.seg_o), 64'(model_seg(1'b0, 24'h0, 6'h0, 6'h0, 1'b0)));
        check("rst.busy", 64'(bus.busy_o), 64'd0);
        check("rst.ovf", 64'(bus.ovf_o), 64'd0);
        reset = 1'b0;

        do_load("hex12abcf", 1'b0, 24'h12ABCF, 6'h00, 6'h00, 0);
        bus.value_i = 24'hFFFFFF;
        repeat (4) @(negedge clk);
        check("hex_hold.seg", 64'(bus.seg_o),
              64'(model_seg(1'b0, 24'h12ABCF, 6'h00, 6'h00, 1'b0)));

        do_load("dec123456", 1'b1, 24'd123456, 6'h00, 6'h00, 0);
        do_load("dec42", 1'b1, 24'd42, 6'h00, 6'h00, 0);
        do_load("dec1000000", 1'b1, 24'd1000000, 6'h00, 6'h00, 0);
        do_load("dec999999", 1'b1, 24'd999999, 6'h00, 6'h00, 0);
        do_load("decmax", 1'b1, 24'h0FFFFF, 6'b000011, 6'h00, 0);
        do_load("dec0", 1'b1, 24'd0, 6'h00, 6'h00, 0);
        do_load("hexdp", 1'b0, 24'h0A0050, 6'b101001, 6'h00, 0);
        do_load("glitch", 1'b1, 24'd123456, 6'h00, 6'h00, 5);

        do_load("blink", 1'b0, 24'h00000F, 6'b000010, 6'b000001, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("blink.seg", 64'(bus.seg_o),
                  64'(model_seg(1'b0, 24'h00000F, 6'b000010, 6'b000001, cur_phase())));
        end

        @(negedge clk);
        bus.load_i  = 1'b1;
        bus.mode_i  = 1'b1;
        bus.value_i = 24'd654321;
        @(negedge clk);
        bus.load_i = 1'b0;
        repeat (9) @(negedge clk);
        check("midconv.busy_pre", 64'(bus.busy_o), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst.busy", 64'(bus.busy_o), 64'd0);
        check("midrst.ovf", 64'(bus.ovf_o), 64'd0);
        check("midrst.seg", 64'(bus.seg_o), 64'(model_seg(1'b0, 24'h0, 6'h0, 6'h0, 1'b0)));
        repeat (2) @(negedge clk);
        check("midrst.hold", 64'(bus.seg_o), 64'(model_seg(1'b0, 24'h0, 6'h0, 6'h0, 1'b0)));

        do_load("postrst", 1'b0, 24'h654321, 6'h00, 6'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
